// File: rtl/floating_coprocessor.sv
// rtl/floating_coprocessor.sv - binary16 add/subtract coprocessor, two-stage streaming pipeline
// Stage 1 captures operands; stage 2 registers the rounded result and status flags.
module floating_coprocessor #(
  parameter int DATA_WIDTH      = 16,
  parameter int SIG_WIDTH       = 11,
  parameter int EXP_WIDTH       = 5,
  parameter int IEEE_COMPILANCE = 1,
  parameter int STATUS_BIT      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rdData_input1_i,
  input  logic [DATA_WIDTH-1:0] rdData_input2_i,
  input  logic                  rdData_inst_op_i,
  input  logic [2:0]            rdData_inst_rnd_i,
  output logic [STATUS_BIT-1:0] getResult_status_output_ff_o,
  output logic [DATA_WIDTH-1:0] getResult_data_ff_o
);
  localparam int FW = SIG_WIDTH - 1;
  localparam int XW = SIG_WIDTH + 3;
  localparam int EW = EXP_WIDTH + 2;
  localparam bit FTZ = (IEEE_COMPILANCE == 0);
  localparam logic [EXP_WIDTH-1:0] EMAX    = '1;
  localparam logic [EXP_WIDTH-1:0] EMAX_M1 = EMAX - 1'b1;

  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  op_q;
  logic [2:0]            rnd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 1'b0;
      rnd_q <= '0;
    end else begin
      a_q   <= rdData_input1_i;
      b_q   <= rdData_input2_i;
      op_q  <= rdData_inst_op_i;
      rnd_q <= rdData_inst_rnd_i;
    end
  end

  logic                  a_s, b_s, a_nan, b_nan, a_inf, b_inf, is_nan, eff_sub, swap, x_s;
  logic [EXP_WIDTH-1:0]  a_e, b_e, x_e, y_e;
  logic [FW-1:0]         a_f, b_f, x_f, y_f;
  logic [SIG_WIDTH-1:0]  x_sig, y_sig;
  logic [EW-1:0]         x_ee, y_ee, diff, lz, sh, e_n;
  logic [XW-1:0]         y_ext, y_al, norm;
  logic [XW:0]           sum;
  logic                  g_bit, lsb, rest, inexact, round_up, to_inf, ovf, sub_norm;
  logic [SIG_WIDTH:0]    mant_r;
  logic [EW+FW-1:0]      enc;
  logic [DATA_WIDTH-1:0] res_data;
  logic [STATUS_BIT-1:0] res_status;

  // In flush-to-zero mode denormal fractions vanish and NaN payloads read as Inf.
  assign a_s   = a_q[DATA_WIDTH-1];
  assign b_s   = b_q[DATA_WIDTH-1] ^ op_q;
  assign a_e   = a_q[DATA_WIDTH-2 -: EXP_WIDTH];
  assign b_e   = b_q[DATA_WIDTH-2 -: EXP_WIDTH];
  assign a_f   = (FTZ && a_e == '0) ? '0 : a_q[FW-1:0];
  assign b_f   = (FTZ && b_e == '0) ? '0 : b_q[FW-1:0];
  assign a_nan = !FTZ && a_e == EMAX && a_f != '0;
  assign b_nan = !FTZ && b_e == EMAX && b_f != '0;
  assign a_inf = a_e == EMAX && (FTZ || a_f == '0);
  assign b_inf = b_e == EMAX && (FTZ || b_f == '0);

  assign eff_sub = a_s ^ b_s;
  assign is_nan  = a_nan | b_nan | (a_inf & b_inf & eff_sub);
  assign swap    = {b_e, b_f} > {a_e, a_f};
  assign x_e     = swap ? b_e : a_e;
  assign y_e     = swap ? a_e : b_e;
  assign x_f     = swap ? b_f : a_f;
  assign y_f     = swap ? a_f : b_f;
  assign x_s     = swap ? b_s : a_s;
  assign x_sig   = {x_e != '0, x_f};
  assign y_sig   = {y_e != '0, y_f};
  assign x_ee    = (x_e == '0) ? EW'(1) : EW'(x_e);
  assign y_ee    = (y_e == '0) ? EW'(1) : EW'(y_e);
  assign diff    = x_ee - y_ee;

  always_comb begin
    y_ext = {y_sig, 3'b000};
    y_al  = '0;
    if (diff >= EW'(XW - 1))
      y_al = {{(XW-1){1'b0}}, |y_sig};
    else
      y_al = (y_ext >> diff) | {{(XW-1){1'b0}}, |(y_ext & ~({XW{1'b1}} << diff))};
    sum = eff_sub ? ({1'b0, x_sig, 3'b000} - {1'b0, y_al})
                  : ({1'b0, x_sig, 3'b000} + {1'b0, y_al});

    lz = EW'(XW);
    for (int i = 0; i < XW; i++)
      if (sum[i]) lz = EW'(XW - 1 - i);
    // Left shift stops at the minimum exponent so results degrade into denormals.
    sh = (lz > x_ee - EW'(1)) ? x_ee - EW'(1) : lz;
    if (sum[XW]) begin
      norm = {sum[XW:2], |sum[1:0]};
      e_n  = x_ee + EW'(1);
    end else begin
      norm = sum[XW-1:0] << sh;
      e_n  = x_ee - sh;
    end

    lsb     = norm[3];
    g_bit   = norm[2];
    rest    = |norm[1:0];
    inexact = |norm[2:0];
    case (rnd_q)
      3'd1:    round_up = 1'b0;
      3'd2:    round_up = inexact & ~x_s;
      3'd3:    round_up = inexact & x_s;
      3'd4:    round_up = g_bit;
      3'd5:    round_up = inexact;
      default: round_up = g_bit & (rest | lsb);
    endcase
    case (rnd_q)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = ~x_s;
      3'd3:    to_inf = x_s;
      default: to_inf = 1'b1;
    endcase

    // Adding the significand onto (exponent-1) lets hidden bit and rounding carry bump the exponent.
    mant_r   = {1'b0, norm[XW-1:3]} + {{SIG_WIDTH{1'b0}}, round_up};
    enc      = {e_n - EW'(1), {FW{1'b0}}} + {{EXP_WIDTH{1'b0}}, mant_r};
    ovf      = enc >= {2'b00, EMAX, {FW{1'b0}}};
    sub_norm = enc[EW+FW-1:FW] == '0;

    res_data   = '0;
    res_status = '0;
    if (is_nan) begin
      res_data      = {1'b0, EMAX, 1'b1, {(FW-1){1'b0}}};
      res_status[2] = 1'b1;
    end else if (a_inf | b_inf) begin
      res_data      = {a_inf ? a_s : b_s, EMAX, {FW{1'b0}}};
      res_status[1] = 1'b1;
    end else if (sum == '0) begin
      res_data      = {eff_sub ? (rnd_q == 3'd3) : a_s, {(DATA_WIDTH-1){1'b0}}};
      res_status[0] = 1'b1;
    end else if (ovf) begin
      res_data      = to_inf ? {x_s, EMAX, {FW{1'b0}}} : {x_s, EMAX_M1, {FW{1'b1}}};
      res_status[1] = to_inf;
      res_status[4] = 1'b1;
      res_status[5] = 1'b1;
    end else if (sub_norm && (FTZ || enc == '0)) begin
      res_data      = {x_s, {(DATA_WIDTH-1){1'b0}}};
      res_status[0] = 1'b1;
      res_status[3] = 1'b1;
      res_status[5] = 1'b1;
    end else begin
      res_data      = {x_s, enc[DATA_WIDTH-2:0]};
      res_status[3] = sub_norm;
      res_status[5] = inexact;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      getResult_data_ff_o          <= '0;
      getResult_status_output_ff_o <= '0;
    end else begin
      getResult_data_ff_o          <= res_data;
      getResult_status_output_ff_o <= res_status;
    end
  end
endmodule

// File: tb/tb_floating_coprocessor.sv
// tb/tb_floating_coprocessor.sv - self-checking bench for floating_coprocessor
// Directed vector table, reset/flush sequence, then random operands against an exact-arithmetic model.
module tb_floating_coprocessor;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_a, in_b;
  logic        in_op;
  logic [2:0]  in_rnd;
  logic [7:0]  st;
  logic [15:0] dat;

  int checks = 0;
  int failures = 0;

  floating_coprocessor dut (
    .clk                          (clk),
    .rst                          (rst),
    .rdData_input1_i              (in_a),
    .rdData_input2_i              (in_b),
    .rdData_inst_op_i             (in_op),
    .rdData_inst_rnd_i            (in_rnd),
    .getResult_status_output_ff_o (st),
    .getResult_data_ff_o          (dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [2:0]  rnd;
    logic [15:0] d;
    logic [7:0]  s;
  } vec_t;

  localparam int NT = 13;
  vec_t tbl[NT];

  localparam longint MAXV = 64'd65504 << 24;

  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [23:0] pe0, pe1;
  string       pn0, pn1;

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got data=%h status=%h, expected data=%h status=%h",
               nm, act[23:8], act[7:0], exp_v[23:8], exp_v[7:0]);
    end
  endtask

  // One clock of streaming: check the op issued two cycles ago, then drive the next one.
  task automatic cycle(input bit v, input logic [15:0] a, input logic [15:0] b, input logic op,
                       input logic [2:0] rnd, input logic [15:0] ed, input logic [7:0] es,
                       input string nm);
    @(negedge clk);
    if (pv1) check(pn1, {dat, st}, pe1);
    pv1 = pv0; pe1 = pe0; pn1 = pn0;
    pv0 = v;   pe0 = {ed, es}; pn0 = nm;
    in_a = a; in_b = b; in_op = op; in_rnd = rnd;
  endtask

  function automatic int msb(input longint v);
    int r = 0;
    for (int i = 0; i < 63; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Magnitude in units of 2^-24 (the smallest denormal).
  function automatic longint mag(input logic [15:0] x);
    if (x[14:10] == 5'd0) return longint'(x[9:0]);
    return longint'({1'b1, x[9:0]}) << (x[14:10] - 1);
  endfunction

  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic op,
                       input logic [2:0] rnd, output logic [15:0] d, output logic [7:0] s);
    logic   sa, sb, an, bn, ai, bi, sign, up, to_inf;
    longint va, vb, sm, m, q, k, rem, r;
    int     e;
    sa = a[15];
    sb = b[15] ^ op;
    an = a[14:10] == 5'h1f && a[9:0] != 0;
    bn = b[14:10] == 5'h1f && b[9:0] != 0;
    ai = a[14:10] == 5'h1f && a[9:0] == 0;
    bi = b[14:10] == 5'h1f && b[9:0] == 0;
    if (an || bn || (ai && bi && sa != sb)) begin
      d = 16'h7E00; s = 8'h04;
    end else if (ai || bi) begin
      d = {ai ? sa : sb, 15'h7C00}; s = 8'h02;
    end else begin
      va = sa ? -mag(a) : mag(a);
      vb = sb ? -mag(b) : mag(b);
      sm = va + vb;
      if (sm == 0) begin
        sign = (sa == sb) ? sa : (rnd == 3'd3);
        d = {sign, 15'h0}; s = 8'h01;
      end else begin
        sign = sm < 0;
        m = sign ? -sm : sm;
        rem = 0;
        if (m < 2048) r = m;
        else begin
          e = msb(m);
          q = longint'(1) << (e - 10);
          k = m / q;
          rem = m % q;
          case (rnd)
            3'd1:    up = 1'b0;
            3'd2:    up = !sign && rem != 0;
            3'd3:    up = sign && rem != 0;
            3'd4:    up = rem >= q / 2;
            3'd5:    up = rem != 0;
            default: up = rem > q / 2 || (rem == q / 2 && k[0]);
          endcase
          r = (k + longint'(up)) * q;
        end
        if (r > MAXV) begin
          to_inf = (rnd == 3'd1) ? 1'b0 : (rnd == 3'd2) ? !sign : (rnd == 3'd3) ? sign : 1'b1;
          d = to_inf ? {sign, 15'h7C00} : {sign, 15'h7BFF};
          s = to_inf ? 8'h32 : 8'h30;
        end else begin
          if (r < 1024) d = {sign, r[14:0]};
          else begin
            e = msb(r);
            d = {sign, 5'(e - 9), 10'((r >> (e - 10)) - 1024)};
          end
          s = (r < 1024 ? 8'h08 : 8'h00) | (rem != 0 ? 8'h20 : 8'h00);
        end
      end
    end
  endtask

  logic [15:0] ra, rb, ed;
  logic        rop;
  logic [2:0]  rr;
  logic [7:0]  es;

  initial begin
    tbl[0]  = '{16'h3C00, 16'h3C00, 1'b0, 3'd0, 16'h4000, 8'h00};
    tbl[1]  = '{16'h3C00, 16'h3C00, 1'b1, 3'd0, 16'h0000, 8'h01};
    tbl[2]  = '{16'h3C00, 16'h3C00, 1'b1, 3'd3, 16'h8000, 8'h01};
    tbl[3]  = '{16'h3C00, 16'h1000, 1'b0, 3'd0, 16'h3C00, 8'h20};
    tbl[4]  = '{16'h3C00, 16'h1000, 1'b0, 3'd2, 16'h3C01, 8'h20};
    tbl[5]  = '{16'h7BFF, 16'h7BFF, 1'b0, 3'd0, 16'h7C00, 8'h32};
    tbl[6]  = '{16'h7BFF, 16'h7BFF, 1'b0, 3'd1, 16'h7BFF, 8'h30};
    tbl[7]  = '{16'h7C00, 16'h7C00, 1'b1, 3'd0, 16'h7E00, 8'h04};
    tbl[8]  = '{16'h0001, 16'h0001, 1'b0, 3'd0, 16'h0002, 8'h08};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 3'd0, 16'h8000, 8'h01};
    tbl[10] = '{16'hFBFF, 16'hFBFF, 1'b0, 3'd2, 16'hFBFF, 8'h30};
    tbl[11] = '{16'hFBFF, 16'hFBFF, 1'b0, 3'd3, 16'hFC00, 8'h32};
    tbl[12] = '{16'h7E00, 16'h3C00, 1'b0, 3'd0, 16'h7E00, 8'h04};

    rst = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_rnd = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", {dat, st}, 24'h0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < NT; i++)
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rnd, tbl[i].d, tbl[i].s,
            $sformatf("vec%0d", i));
    repeat (2) cycle(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 8'h0, "flush");

    for (int i = 0; i < 4; i++)
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rnd, tbl[i].d, tbl[i].s,
            $sformatf("pre_rst%0d", i));
    #7 rst = 1'b0;
    in_a = '0; in_b = '0; in_op = 1'b0; in_rnd = '0;
    #1 check("rst_async_clear", {dat, st}, 24'h0);
    @(posedge clk);
    #1 check("rst_hold", {dat, st}, 24'h0);
    pv0 = 1'b0; pv1 = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) check("rst_flushed_data", {dat, 8'h00}, 24'h0);
    for (int i = 4; i < NT; i++)
      cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].rnd, tbl[i].d, tbl[i].s,
            $sformatf("post_rst%0d", i));
    repeat (2) cycle(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 8'h0, "flush");

    for (int i = 0; i < 600; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rb[14:10] = ra[14:10] ^ 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rb[9:0] = ra[9:0];
      if ($urandom_range(0, 7) == 0) begin
        ra[14:10] = 5'($urandom_range(0, 2));
        rb[14:10] = 5'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 9) == 0) begin
        ra[14:10] = 5'd30;
        rb[14:10] = 5'd30;
      end
      rop = 1'($urandom_range(0, 1));
      rr  = 3'($urandom_range(0, 7));
      model(ra, rb, rop, rr, ed, es);
      cycle(1'b1, ra, rb, rop, rr, ed, es,
            $sformatf("rand%0d a=%h b=%h op=%0d rnd=%0d", i, ra, rb, rop, rr));
    end
    repeat (2) cycle(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 8'h0, "flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
